memory_arbiter: RTL and testbench

//  Shares the single RAM port between the instruction-fetch (iREN) and data (dREN/dWEN) requesters

---
 rtl/memory_arbiter_if.sv | 33 +++
 rtl/memory_arbiter.sv | 95 +++++++++
 tb/tb_memory_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// Bus bundle between the control unit, the memory arbiter and the single-port RAM.
// The master modport is the arbiter's view; slave is the control-unit/RAM side.
interface memory_arbiter_if;
  logic        halt;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dhit;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ready;
  logic        mem_err;
  logic        idle;

  modport master (
    input  halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err, idle
  );

  modport slave (
    output halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err, idle
  );
endinterface

// File: rtl/memory_arbiter.sv
// Shares one RAM port between instruction fetch and data access: data has priority,
// a streak limit guarantees fetch progress, a watchdog aborts hung accesses.
module memory_arbiter #(
  parameter int TIMEOUT     = 64,
  parameter int MAX_DSTREAK = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  memory_arbiter_if.master     bus,
  output logic [1:0]           fsm_state
);

  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam int SW = $clog2(MAX_DSTREAK + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DACC = 2'd1, IACC = 2'd2} state_t;

  state_t        state, next_state;
  logic [31:0]   addr_q, store_q;
  logic          op_wr;
  logic [SW-1:0] streak;
  logic [WW-1:0] wdog;
  logic          mem_err_q;
  logic          grant_d, grant_i, abort, ihit, dhit;

  // Grants are suppressed during reset so the reset-state outputs stay clean.
  assign grant_d = !RST && !bus.halt && (bus.dREN || bus.dWEN) &&
                   !(bus.iREN && (streak == SW'(MAX_DSTREAK)));
  assign grant_i = !RST && !bus.halt && !grant_d && bus.iREN;

  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    dhit       = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (grant_d)      next_state = DACC;
        else if (grant_i) next_state = IACC;
      end
      DACC, IACC: begin
        if (bus.ram_ready) begin
          dhit       = !RST && (state == DACC);
          ihit       = !RST && (state == IACC);
          next_state = IDLE;
        end else if (wdog == WW'(TIMEOUT - 1)) begin
          abort      = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign bus.ihit     = ihit;
  assign bus.dhit     = dhit;
  assign bus.iload    = ihit ? bus.ramload : 32'd0;
  assign bus.dload    = (dhit && !op_wr) ? bus.ramload : 32'd0;
  assign bus.ramREN   = (state == IACC) || ((state == DACC) && !op_wr);
  assign bus.ramWEN   = (state == DACC) && op_wr;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.mem_err  = mem_err_q;
  assign bus.idle     = (state == IDLE) && !grant_d && !grant_i;
  assign fsm_state    = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      addr_q    <= '0;
      store_q   <= '0;
      op_wr     <= 1'b0;
      streak    <= '0;
      wdog      <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state <= next_state;
      // Counter sits at zero in IDLE, so every access starts with a fresh budget.
      wdog  <= (state == IDLE) ? '0 : wdog + 1'b1;
      if (grant_d) begin
        addr_q  <= bus.daddr;
        store_q <= bus.dstore;
        op_wr   <= bus.dWEN;
      end else if (grant_i) begin
        addr_q  <= bus.iaddr;
      end
      if (dhit)
        streak <= bus.iREN ? ((streak == SW'(MAX_DSTREAK)) ? streak : streak + 1'b1) : '0;
      else if (ihit)
        streak <= '0;
      if (abort) mem_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: expected hits are queued at stimulus time and
// popped by an independent monitor; strobe/status checks are made inline.
module tb_memory_arbiter;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] fsm_state;
  int         vectors = 0;
  int         miscompares = 0;
  logic [32:0] exp_q[$];

  memory_arbiter_if bus();

  memory_arbiter #(.TIMEOUT(8), .MAX_DSTREAK(4)) dut (
    .CLK(clk), .RST(rst), .bus(bus), .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // RAM model: read data is a fixed function of the address.
  assign bus.ramload = bus.ramaddr ^ K;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic i, input logic d, input logic w);
    bus.iREN = i;
    bus.dREN = d;
    bus.dWEN = w;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Scoreboard monitor: each hit is {is_data, load}
  always @(negedge clk) begin
    if (bus.ihit && bus.dhit) begin
      vectors++;
      miscompares++;
      $display("FAIL both_hits: ihit=1 dhit=1 expected at most one at %0t", $time);
    end else if (bus.ihit || bus.dhit) begin
      logic [32:0] act, expv;
      act = {bus.dhit, bus.dhit ? bus.dload : bus.iload};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_hit: got %h expected no hit at %0t", act, $time);
      end else begin
        expv = exp_q.pop_front();
        if (act !== expv) begin
          miscompares++;
          $display("FAIL hit_data: got %h expected %h at %0t", act, expv, $time);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.halt = 1'b0;
    set_req(1'b1, 1'b0, 1'b0);
    bus.iaddr = 32'h40;
    bus.daddr = '0;
    bus.dstore = '0;
    bus.ram_ready = 1'b1;
    step(); step();

    // Reset state, with a fetch request already waiting
    chk("rst_idle", {31'd0, bus.idle}, 32'd1);
    chk("rst_ramren", {31'd0, bus.ramREN}, 32'd0);
    chk("rst_ramaddr", bus.ramaddr, 32'd0);
    chk("rst_mem_err", {31'd0, bus.mem_err}, 32'd0);
    chk("rst_state", {30'd0, fsm_state}, 32'd0);

    // 1: single fetch, RAM always ready
    rst = 1'b0;
    #1;
    chk("t1_grant_not_idle", {31'd0, bus.idle}, 32'd0);
    exp_q.push_back({1'b0, 32'h40 ^ K});
    step();
    chk("t1_ramren", {31'd0, bus.ramREN}, 32'd1);
    chk("t1_ramaddr", bus.ramaddr, 32'h40);
    chk("t1_ihit", {31'd0, bus.ihit}, 32'd1);
    set_req(1'b0, 1'b0, 1'b0);
    step();
    chk("t1_strobe_drop", {31'd0, bus.ramREN}, 32'd0);
    chk("t1_idle", {31'd0, bus.idle}, 32'd1);

    // 2: write with three wait states
    bus.ram_ready = 1'b0;
    bus.daddr = 32'h100;
    bus.dstore = 32'hDEADBEEF;
    set_req(1'b0, 1'b0, 1'b1);
    exp_q.push_back({1'b1, 32'd0});
    step();
    set_req(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("t2_ramwen", {31'd0, bus.ramWEN}, 32'd1);
      chk("t2_ramren", {31'd0, bus.ramREN}, 32'd0);
      if (k == 0) begin
        chk("t2_ramaddr", bus.ramaddr, 32'h100);
        chk("t2_ramstore", bus.ramstore, 32'hDEADBEEF);
      end
      bus.ram_ready = (k == 3);
      step();
    end
    chk("t2_wen_drop", {31'd0, bus.ramWEN}, 32'd0);

    // 3: fetch and data contend; four data grants then one forced fetch
    bus.ram_ready = 1'b1;
    bus.daddr = 32'h200;
    bus.iaddr = 32'h300;
    set_req(1'b1, 1'b1, 1'b0);
    for (int a = 0; a < 10; a++) begin
      if (a == 4 || a == 9) exp_q.push_back({1'b0, 32'h300 ^ K});
      else                  exp_q.push_back({1'b1, 32'h200 ^ K});
    end
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) chk("t3_bubble", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
      else            chk("t3_access", {31'd0, bus.ramREN}, 32'd1);
      if (k == 19) set_req(1'b0, 1'b0, 1'b0);
      step();
    end
    chk("t3_idle_after", {31'd0, bus.idle}, 32'd1);

    // 4: fetch never answered -> watchdog abort after 8 cycles
    bus.ram_ready = 1'b0;
    bus.iaddr = 32'h80;
    set_req(1'b1, 1'b0, 1'b0);
    step();
    set_req(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      chk("t4_ramren_held", {31'd0, bus.ramREN}, 32'd1);
      chk("t4_no_err_yet", {31'd0, bus.mem_err}, 32'd0);
      step();
    end
    chk("t4_ramren_drop", {31'd0, bus.ramREN}, 32'd0);
    chk("t4_mem_err", {31'd0, bus.mem_err}, 32'd1);
    repeat (5) step();
    chk("t4_mem_err_sticky", {31'd0, bus.mem_err}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_mem_err_cleared", {31'd0, bus.mem_err}, 32'd0);

    // 5: halt raised during a data read
    bus.daddr = 32'h400;
    set_req(1'b1, 1'b1, 1'b0);
    step();
    bus.halt = 1'b1;
    chk("t5_dacc", {31'd0, bus.ramREN}, 32'd1);
    chk("t5_dacc_addr", bus.ramaddr, 32'h400);
    step();
    bus.ram_ready = 1'b1;
    exp_q.push_back({1'b1, 32'h400 ^ K});
    step();
    for (int k = 0; k < 12; k++) begin
      chk("t5_halt_idle", {31'd0, bus.idle}, 32'd1);
      chk("t5_halt_strobes", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
      step();
    end
    set_req(1'b0, 1'b0, 1'b0);
    bus.halt = 1'b0;
    step();

    // 6: read+write together is a write; reset while waiting kills it
    bus.ram_ready = 1'b0;
    bus.daddr = 32'h20;
    bus.dstore = 32'h1234_5678;
    set_req(1'b0, 1'b1, 1'b1);
    step();
    set_req(1'b0, 1'b0, 1'b0);
    chk("t6_ramwen", {31'd0, bus.ramWEN}, 32'd1);
    chk("t6_ramren", {31'd0, bus.ramREN}, 32'd0);
    chk("t6_ramaddr", bus.ramaddr, 32'h20);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_strobes", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
    chk("t6_rst_state", {30'd0, fsm_state}, 32'd0);
    repeat (3) step();
    chk("t6_idle", {31'd0, bus.idle}, 32'd1);

    // Drain check with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) step();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d hits outstanding, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
